// File: rtl/secded_pkg.sv
// Shared SEC-DED definitions: code geometry helpers, reference encoder and
// the error classification used by the pipelined decoder.
package secded_pkg;

  localparam int MAX_DW  = 120;
  localparam int MAX_CHK = 8;

  typedef enum logic [1:0] {CLEAN, SBE_DATA, SBE_CHK, DBE} err_class_t;

  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  // Position of data bit idx: the idx-th non-power-of-two position from 3 upward.
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int k = 3; k < 256; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (cnt == idx && pos == 0) pos = k;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [MAX_CHK-1:0] secded_encode(input logic [MAX_DW-1:0] data,
                                                       input int dw);
    logic [MAX_CHK-1:0] chk;
    logic par;
    int p;
    int pos;
    p   = calc_p(dw);
    chk = '0;
    par = 1'b0;
    for (int i = 0; i < MAX_DW; i++) begin
      if (i < dw && data[i]) begin
        pos = data_pos(i);
        for (int j = 0; j < MAX_CHK - 1; j++)
          if (j < p && pos[j]) chk[j] = ~chk[j];
        par = ~par;
      end
    end
    for (int j = 0; j < MAX_CHK - 1; j++)
      if (j < p && chk[j]) par = ~par;
    chk[p] = par;
    return chk;
  endfunction

endpackage

// File: rtl/secded_pipe_decoder_syndrome.sv
// Combinational syndrome and overall-parity generator for one received word.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int P      = 6
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [P:0]        check_i,
  output logic [P-1:0]      syn_o,
  output logic              par_o
);

  logic [P-1:0] term [DATA_W];

  for (genvar i = 0; i < DATA_W; i++) begin : g_term
    localparam logic [P-1:0] POS = P'(data_pos(i));
    assign term[i] = data_i[i] ? POS : '0;
  end

  // Hamming check j lives at position 2^j, so it only toggles syndrome bit j.
  always_comb begin
    syn_o = check_i[P-1:0];
    for (int i = 0; i < DATA_W; i++) syn_o = syn_o ^ term[i];
  end

  assign par_o = (^data_i) ^ (^check_i);

endmodule

// File: rtl/secded_pipe_decoder.sv
// Two-stage SEC-DED decoder with valid/ready streaming, syndrome reporting
// and saturating single/double error counters.
module secded_pipe_decoder
  import secded_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int P      = calc_p(DATA_W),
  localparam int CHK_W  = P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_check,
  input  logic              corr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syndrome,
  output logic              out_sbe,
  output logic              out_dbe,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  sbe_count,
  output logic [CNT_W-1:0]  dbe_count
);

  localparam logic [P-1:0]     N_POS   = P'(DATA_W + P);
  localparam logic [P-1:0]     SYN_ONE = {{(P-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              s2_adv, s1_adv;
  logic [P-1:0]      syn;
  logic              par;

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [P-1:0]      s1_syn_q;
  logic              s1_par_q;
  logic              s1_corr_q;

  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_data_q;
  logic [P-1:0]      s2_syn_q;
  logic              s2_sbe_q;
  logic              s2_dbe_q;

  logic [CNT_W-1:0]  sbe_cnt_q, sbe_cnt_d;
  logic [CNT_W-1:0]  dbe_cnt_q, dbe_cnt_d;

  err_class_t        cls;
  logic [DATA_W-1:0] flip;
  logic [DATA_W-1:0] fix_data;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  secded_syndrome #(.DATA_W(DATA_W), .P(P)) u_syndrome (
    .data_i  (in_data),
    .check_i (in_check),
    .syn_o   (syn),
    .par_o   (par)
  );

  // ---- stage 1: capture word, syndrome, parity and correction enable ----
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_data_q <= in_data;
      s1_syn_q  <= syn;
      s1_par_q  <= par;
      s1_corr_q <= corr_en;
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_flip
    localparam logic [P-1:0] POS = P'(data_pos(i));
    assign flip[i] = (s1_syn_q == POS);
  end

  always_comb begin
    cls = CLEAN;
    if (s1_par_q) begin
      if ((s1_syn_q & (s1_syn_q - SYN_ONE)) == '0) cls = SBE_CHK;
      else if (s1_syn_q > N_POS)                   cls = DBE;
      else                                         cls = SBE_DATA;
    end else if (s1_syn_q != '0) begin
      cls = DBE;
    end
    fix_data = s1_data_q;
    if (cls == SBE_DATA && s1_corr_q) fix_data = s1_data_q ^ flip;
  end

  // ---- stage 2: corrected data and flags, held while stalled ----
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_syn_q   <= '0;
      s2_sbe_q   <= 1'b0;
      s2_dbe_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= fix_data;
        s2_syn_q  <= s1_syn_q;
        s2_sbe_q  <= (cls == SBE_DATA) || (cls == SBE_CHK);
        s2_dbe_q  <= (cls == DBE);
      end
    end
  end

  always_comb begin
    sbe_cnt_d = sbe_cnt_q;
    dbe_cnt_d = dbe_cnt_q;
    if (cnt_clear) begin
      sbe_cnt_d = '0;
      dbe_cnt_d = '0;
    end else if (s2_valid_q && out_ready) begin
      if (s2_sbe_q && sbe_cnt_q != '1) sbe_cnt_d = sbe_cnt_q + CNT_ONE;
      if (s2_dbe_q && dbe_cnt_q != '1) dbe_cnt_d = dbe_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else begin
      sbe_cnt_q <= sbe_cnt_d;
      dbe_cnt_q <= dbe_cnt_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_syndrome = s2_syn_q;
  assign out_sbe      = s2_sbe_q;
  assign out_dbe      = s2_dbe_q;
  assign sbe_count    = sbe_cnt_q;
  assign dbe_count    = dbe_cnt_q;

endmodule

// File: tb/tb_secded_pipe_decoder.sv
// Scoreboard bench for secded_pipe_decoder (DATA_W=32, CNT_W=4).
module tb_secded_pipe_decoder;
  import secded_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int PW = 6;
  localparam int CK = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CK-1:0] in_check = '0;
  logic          corr_en = 1'b1;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_syndrome;
  logic          out_sbe, out_dbe;
  logic          cnt_clear = 1'b0;
  logic [CW-1:0] sbe_count, dbe_count;

  secded_pipe_decoder #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_check     (in_check),
    .corr_en      (corr_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_syndrome (out_syndrome),
    .out_sbe      (out_sbe),
    .out_dbe      (out_dbe),
    .cnt_clear    (cnt_clear),
    .sbe_count    (sbe_count),
    .dbe_count    (dbe_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] syn;
    logic          sbe;
    logic          dbe;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t q[$];
  int   applied = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per delivered word, and checks hold stability.
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d;
  logic [PW-1:0] held_s;
  logic          held_sbe, held_dbe;
  exp_t          e;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_data", 64'(out_data), 64'(held_d));
        chk("stall_flags", 64'({out_syndrome, out_sbe, out_dbe}),
            64'({held_s, held_sbe, held_dbe}));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          e = q.pop_front();
          chk("data", 64'(out_data), 64'(e.data));
          chk("syndrome", 64'(out_syndrome), 64'(e.syn));
          chk("sbe", 64'(out_sbe), 64'(e.sbe));
          chk("dbe", 64'(out_dbe), 64'(e.dbe));
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(2));
        end
      end
      held_v   = out_valid && !out_ready;
      held_d   = out_data;
      held_s   = out_syndrome;
      held_sbe = out_sbe;
      held_dbe = out_dbe;
    end
  end

  task automatic drive(input logic [DW-1:0] d, input logic [DW-1:0] fd,
                       input logic [CK-1:0] fc, input logic ce);
    logic [MAX_CHK-1:0] c;
    c        = secded_encode(MAX_DW'(d), DW);
    in_data  = d ^ fd;
    in_check = c[CK-1:0] ^ fc;
    corr_en  = ce;
    in_valid = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] ed, input logic [PW-1:0] es,
                      input logic esb, input logic edb, input bit lat);
    exp_t x;
    x.data = ed; x.syn = es; x.sbe = esb; x.dbe = edb; x.acc = cyc; x.lat = lat;
    q.push_back(x);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] fd,
                      input logic [CK-1:0] fc, input logic ce,
                      input logic [DW-1:0] ed, input logic [PW-1:0] es,
                      input logic esb, input logic edb, input bit lat);
    bit ok;
    ok = 1'b0;
    drive(d, fd, fc, ce);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      applied++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready stayed %0b expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    push(ed, es, esb, edb, lat);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    if (q.size() != 0) begin
      applied++;
      miscompares++;
      $display("FAIL drain_timeout: %0d words outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  logic [DW-1:0] bp_words [6];
  int            accepted;
  bit            took;
  bit            seen;
  int            fbit [5];
  logic [PW-1:0] fsyn [5];

  initial begin
    fbit = '{0, 1, 2, 3, 4};
    fsyn = '{6'd3, 6'd5, 6'd6, 6'd7, 6'd9};
    bp_words = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'h5A5A_A5A5, 32'h0F0F_F0F0, 32'hCAFE_F00D};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_flags", 64'({out_syndrome, out_sbe, out_dbe}), 64'(0));
    chk("rst_counts", 64'({sbe_count, dbe_count}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Clean stream, one word per cycle.
    for (int k = 0; k < 8; k++)
      send(32'hDEADBEEF + 32'(k) * 32'h0101_0101, '0, '0, 1'b1,
           32'hDEADBEEF + 32'(k) * 32'h0101_0101, 6'd0, 1'b0, 1'b0, 1'b1);
    drain();

    // Error classes on 0xDEADBEEF.
    send(32'hDEADBEEF, 32'h1, '0, 1'b1, 32'hDEADBEEF, 6'd3, 1'b1, 1'b0, 1'b1);
    send(32'hDEADBEEF, 32'h1, '0, 1'b0, 32'hDEADBEEE, 6'd3, 1'b1, 1'b0, 1'b1);
    send(32'hDEADBEEF, 32'h3, '0, 1'b1, 32'hDEADBEEC, 6'd6, 1'b0, 1'b1, 1'b1);
    send(32'hDEADBEEF, '0, 7'h01, 1'b1, 32'hDEADBEEF, 6'd1, 1'b1, 1'b0, 1'b1);
    send(32'hDEADBEEF, '0, 7'h40, 1'b1, 32'hDEADBEEF, 6'd0, 1'b1, 1'b0, 1'b1);
    send(32'hDEADBEEF, 32'h0404_0000, 7'h01, 1'b1, 32'hDAA9BEEF, 6'h38, 1'b0, 1'b1, 1'b1);
    drain();
    chk("sbe_count_mixed", 64'(sbe_count), 64'(4));
    chk("dbe_count_mixed", 64'(dbe_count), 64'(2));

    // Backpressure: out_ready low for 4 cycles with input offered.
    out_ready = 1'b0;
    accepted  = 0;
    drive(bp_words[0], '0, '0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      took = in_ready;
      if (took) begin
        push(bp_words[accepted], 6'd0, 1'b0, 1'b0, 1'b0);
        accepted++;
      end
      @(posedge clk);
      #1;
      if (took) drive(bp_words[accepted], '0, '0, 1'b1);
    end
    chk("bp_accepted", 64'(accepted), 64'(2));
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 2; k < 6; k++)
      send(bp_words[k], '0, '0, 1'b1, bp_words[k], 6'd0, 1'b0, 1'b0, 1'b0);
    drain();

    // Saturation of the 4-bit single-error counter.
    for (int k = 0; k < 20; k++)
      send(32'h1234_0000 + 32'(k), 32'h1 << fbit[k % 5], '0, 1'b1,
           32'h1234_0000 + 32'(k), fsyn[k % 5], 1'b1, 1'b0, 1'b1);
    drain();
    chk("sbe_count_sat", 64'(sbe_count), 64'(15));
    chk("dbe_count_hold", 64'(dbe_count), 64'(2));

    // Clear coinciding with an sbe delivery.
    send(32'hDEADBEEF, 32'h4, '0, 1'b1, 32'hDEADBEEF, 6'd6, 1'b1, 1'b0, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("clear_word_seen", 64'(seen), 64'(1));
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    chk("sbe_count_clear", 64'(sbe_count), 64'(0));
    chk("dbe_count_clear", 64'(dbe_count), 64'(0));
    drain();

    // Reset with two words in flight.
    send(32'hDEADBEEF, 32'h3, '0, 1'b1, 32'hDEADBEEC, 6'd6, 1'b0, 1'b1, 1'b1);
    drain();
    chk("dbe_count_pre_rst", 64'(dbe_count), 64'(1));
    out_ready = 1'b0;
    send(32'h1111_1111, '0, '0, 1'b1, 32'h1111_1111, 6'd0, 1'b0, 1'b0, 1'b0);
    send(32'h2222_2222, '0, '0, 1'b1, 32'h2222_2222, 6'd0, 1'b0, 1'b0, 1'b0);
    chk("inflight_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_counts", 64'({sbe_count, dbe_count}), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    send(32'h3333_3333, '0, '0, 1'b1, 32'h3333_3333, 6'd0, 1'b0, 1'b0, 1'b1);
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule
